// File: rtl/key_debounce.sv
// key_debounce: five-key pushbutton front end.
// Each active-low raw key is synchronized, debounced by its own stable-cycle
// counter, and turned into an active-high level plus a one-cycle press pulse.
// Optional build macro KEY_REPEAT_EN adds auto-repeat: a shared counter and a
// two-state FSM re-pulse the single held key after REPEAT_DELAY cycles and then
// every REPEAT_PERIOD cycles. With the macro undefined, one pulse per press.
module key_debounce #(
    parameter int DEBOUNCE_CNT  = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [4:0] KeyRaw,
    output logic [4:0] KeyLevel,
    output logic [4:0] KeyPress
);

    localparam int NK = 5;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [CW-1:0] cnt     [NK];
    logic [CW-1:0] cnt_nxt [NK];
    logic [4:0]    level_nxt;
    logic [4:0]    rise;
    logic [4:0]    rpt_press;

    // Two-flop synchronizer; reset value is all keys released (raw high)
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1 <= 5'b11111;
            sync2 <= 5'b11111;
        end else begin
            sync1 <= KeyRaw;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: count cycles of disagreement, toggle level on the last one
    always_comb begin
        level_nxt = KeyLevel;
        for (int i = 0; i < NK; i++) begin
            cnt_nxt[i] = '0;
            if (~sync2[i] == KeyLevel[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                level_nxt[i] = ~KeyLevel[i];
                cnt_nxt[i]   = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
        end
        rise = level_nxt & ~KeyLevel;
    end

    // Debounce counters and accepted key levels
    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < NK; i++) begin
                cnt[i] <= '0;
            end
            KeyLevel <= '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            KeyLevel <= level_nxt;
        end
    end

`ifdef KEY_REPEAT_EN
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rpt_state_t;

    localparam logic [24:0] DELAY_LAST  = 25'(REPEAT_DELAY - 1);
    localparam logic [24:0] PERIOD_LAST = 25'(REPEAT_PERIOD - 1);
    localparam logic [24:0] RPT_ONE     = 25'(1);

    rpt_state_t  state;
    rpt_state_t  state_nxt;
    logic [24:0] rpt_cnt;
    logic [24:0] rpt_cnt_nxt;
    logic        rpt_fire;
    logic        level_change;
    logic        single_key;

    // Repeat FSM state and shared interval counter
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state   <= IDLE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_cnt_nxt;
        end
    end

    // Repeat decisions: any level change or not-exactly-one key restarts from IDLE
    always_comb begin
        state_nxt    = state;
        rpt_cnt_nxt  = rpt_cnt;
        rpt_fire     = 1'b0;
        level_change = (level_nxt != KeyLevel);
        single_key   = $onehot(KeyLevel);
        if (level_change || !single_key) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rpt_cnt == DELAY_LAST) begin
                        state_nxt   = HOLD;
                        rpt_cnt_nxt = '0;
                        rpt_fire    = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_ONE;
                    end
                end
                HOLD: begin
                    if (rpt_cnt == PERIOD_LAST) begin
                        rpt_cnt_nxt = '0;
                        rpt_fire    = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_ONE;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    rpt_cnt_nxt = '0;
                end
            endcase
        end
        rpt_press = rpt_fire ? KeyLevel : 5'b00000;
    end
`else
    assign rpt_press = 5'b00000;
`endif

    // Press pulse: new accepted presses plus any repeat pulse on the held key
    always_ff @(posedge sysclk) begin
        if (rst) begin
            KeyPress <= '0;
        end else begin
            KeyPress <= rise | rpt_press;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed-vector bench for key_debounce with
// DEBOUNCE_CNT=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. Edge 0 is the first rising
// edge that samples a new KeyRaw value; outputs are sampled 1 ns after each edge.
module tb_key_debounce;

    logic       sysclk;
    logic       rst;
    logic [4:0] KeyRaw;
    logic [4:0] KeyLevel;
    logic [4:0] KeyPress;

    int vectors;
    int errors;

    key_debounce #(
        .DEBOUNCE_CNT (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .sysclk  (sysclk),
        .rst     (rst),
        .KeyRaw  (KeyRaw),
        .KeyLevel(KeyLevel),
        .KeyPress(KeyPress)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic do_reset();
        rst    = 1'b1;
        KeyRaw = 5'b11111;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp_zero;
        exp_zero = 5'b00000;
        rst    = 1'b1;
        KeyRaw = 5'b00000;
        for (int e = 0; e < 8; e++) begin
            @(posedge sysclk);
            #1;
            vectors++;
            if (KeyLevel !== exp_zero) begin
                errors++;
                $display("FAIL reset_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_zero);
            end
            vectors++;
            if (KeyPress !== exp_zero) begin
                errors++;
                $display("FAIL reset_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_zero);
            end
        end
    endtask

    // Left pressed at edge 0, released at edge 12: level 1 over edges 5..16, one pulse at 5
    task automatic test_single_press();
        logic [4:0] exp_lvl;
        logic [4:0] exp_prs;
        do_reset();
        KeyRaw = 5'b11110;
        for (int e = 0; e <= 22; e++) begin
            @(posedge sysclk);
            #1;
            exp_lvl = (e >= 5 && e < 17) ? 5'b00001 : 5'b00000;
            exp_prs = (e == 5) ? 5'b00001 : 5'b00000;
            vectors++;
            if (KeyLevel !== exp_lvl) begin
                errors++;
                $display("FAIL single_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_lvl);
            end
            vectors++;
            if (KeyPress !== exp_prs) begin
                errors++;
                $display("FAIL single_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_prs);
            end
            if (e == 11) KeyRaw = 5'b11111;
        end
    endtask

    // Up low for three sampled cycles only: must be rejected as a glitch
    task automatic test_glitch();
        logic [4:0] exp_zero;
        exp_zero = 5'b00000;
        do_reset();
        KeyRaw = 5'b11011;
        for (int e = 0; e <= 12; e++) begin
            @(posedge sysclk);
            #1;
            vectors++;
            if (KeyLevel !== exp_zero) begin
                errors++;
                $display("FAIL glitch_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_zero);
            end
            vectors++;
            if (KeyPress !== exp_zero) begin
                errors++;
                $display("FAIL glitch_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_zero);
            end
            if (e == 2) KeyRaw = 5'b11111;
        end
    endtask

    // Enter and Right pressed together: both pulse in the same cycle
    task automatic test_simultaneous();
        logic [4:0] exp_lvl;
        logic [4:0] exp_prs;
        do_reset();
        KeyRaw = 5'b01101;
        for (int e = 0; e <= 10; e++) begin
            @(posedge sysclk);
            #1;
            exp_lvl = (e >= 5) ? 5'b10010 : 5'b00000;
            exp_prs = (e == 5) ? 5'b10010 : 5'b00000;
            vectors++;
            if (KeyLevel !== exp_lvl) begin
                errors++;
                $display("FAIL simul_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_lvl);
            end
            vectors++;
            if (KeyPress !== exp_prs) begin
                errors++;
                $display("FAIL simul_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_prs);
            end
        end
    endtask

    // Down held, reset at edges 3 and 4: re-accepted at edge 10 (5 edges after edge 5)
    task automatic test_reset_mid();
        logic [4:0] exp_lvl;
        logic [4:0] exp_prs;
        do_reset();
        KeyRaw = 5'b10111;
        for (int e = 0; e <= 14; e++) begin
            @(posedge sysclk);
            #1;
            exp_lvl = (e >= 10) ? 5'b01000 : 5'b00000;
            exp_prs = (e == 10) ? 5'b01000 : 5'b00000;
            vectors++;
            if (KeyLevel !== exp_lvl) begin
                errors++;
                $display("FAIL rstmid_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_lvl);
            end
            vectors++;
            if (KeyPress !== exp_prs) begin
                errors++;
                $display("FAIL rstmid_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_prs);
            end
            if (e == 2) rst = 1'b1;
            if (e == 4) rst = 1'b0;
        end
    endtask

    // Left held for 60+ cycles: repeat pulses only when auto-repeat is built in
    task automatic test_repeat();
        logic [4:0] exp_lvl;
        logic [4:0] exp_prs;
        logic       pulse;
        do_reset();
        KeyRaw = 5'b11110;
        for (int e = 0; e <= 62; e++) begin
            @(posedge sysclk);
            #1;
`ifdef KEY_REPEAT_EN
            pulse = (e == 5) || (e == 25) || (e == 33) || (e == 41) || (e == 49) || (e == 57);
`else
            pulse = (e == 5);
`endif
            exp_lvl = (e >= 5) ? 5'b00001 : 5'b00000;
            exp_prs = pulse ? 5'b00001 : 5'b00000;
            vectors++;
            if (KeyLevel !== exp_lvl) begin
                errors++;
                $display("FAIL repeat_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_lvl);
            end
            vectors++;
            if (KeyPress !== exp_prs) begin
                errors++;
                $display("FAIL repeat_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_prs);
            end
        end
    endtask

    // Left held, Up joins at edge 30 (accepted at 35): bit 0 repeats stop for good
    task automatic test_repeat_cancel();
        logic [4:0] exp_lvl;
        logic [4:0] exp_prs;
        logic       pulse0;
        do_reset();
        KeyRaw = 5'b11110;
        for (int e = 0; e <= 70; e++) begin
            @(posedge sysclk);
            #1;
`ifdef KEY_REPEAT_EN
            pulse0 = (e == 5) || (e == 25) || (e == 33);
`else
            pulse0 = (e == 5);
`endif
            exp_lvl = ((e >= 5) ? 5'b00001 : 5'b00000) | ((e >= 35) ? 5'b00100 : 5'b00000);
            exp_prs = (pulse0 ? 5'b00001 : 5'b00000) | ((e == 35) ? 5'b00100 : 5'b00000);
            vectors++;
            if (KeyLevel !== exp_lvl) begin
                errors++;
                $display("FAIL cancel_level e=%0d KeyLevel got %b want %b", e, KeyLevel, exp_lvl);
            end
            vectors++;
            if (KeyPress !== exp_prs) begin
                errors++;
                $display("FAIL cancel_press e=%0d KeyPress got %b want %b", e, KeyPress, exp_prs);
            end
            if (e == 29) KeyRaw = 5'b11010;
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        KeyRaw  = 5'b11111;
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_repeat_cancel();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 25000000: hold cycles from accepted press to first repeat pulse; legal range 2..2^25-1.
REQ-003 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses; legal range 2..REPEAT_DELAY.
REQ-004 sysclk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 KeyRaw  input  5  raw pushbuttons, active-low, asynchronous; bit order [4:0] = {Enter, Down, Up, Right, Left}.
REQ-007 KeyLevel  output  5  debounced key state, active-high (1 = pressed).
REQ-008 KeyPress  output  5  one-cycle press/repeat pulse per key, active-high; feeds the Input stage's Left/Right/Up/Down/Enter.

Function
REQ-009 Each KeyRaw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each key SHALL own an independent counter cnt[i] of $clog2(DEBOUNCE_CNT+1) bits.
REQ-011 Counter rule: if the inverted sync2 equals KeyLevel[i], cnt[i] clears to 0; otherwise cnt[i] increments.
REQ-012 When cnt[i] == DEBOUNCE_CNT-1 and the mismatch persists, KeyLevel[i] SHALL toggle at that edge and cnt[i] SHALL clear.
REQ-013 Latency: a clean raw edge first sampled at edge 0 SHALL update KeyLevel after edge DEBOUNCE_CNT+1.
REQ-014 KeyPress[i] SHALL be registered high for exactly one cycle, set at the same edge KeyLevel[i] goes 0->1; release (1->0) SHALL produce no pulse.
REQ-015 A raw glitch shorter than DEBOUNCE_CNT synchronized cycles SHALL leave KeyLevel and KeyPress unchanged.
REQ-016 Keys SHALL be processed independently; simultaneous accepted presses SHALL raise multiple KeyPress bits in the same cycle.
REQ-017 KeyPress SHALL never be high in two consecutive cycles for the same bit.

Reset
REQ-018 While rst is high at a rising edge: sync1, sync2 <= 5'b11111 (released); cnt, KeyLevel, KeyPress, repeat state <= 0.
REQ-019 Reset mid-debounce SHALL discard partial counts; a key held through reset SHALL be re-accepted as a new press DEBOUNCE_CNT+1 cycles after rst deasserts.

Configuration
REQ-020 Macro KEY_REPEAT_EN defined: auto-repeat is compiled in via a single shared repeat counter (25 bits) and a 2-state FSM, IDLE and HOLD.
REQ-021 Transitions: IDLE->HOLD when exactly one KeyLevel bit is set and the counter reaches REPEAT_DELAY-1, emitting KeyPress on that key and reloading the counter.
REQ-022 In HOLD, a repeat pulse SHALL occur every REPEAT_PERIOD cycles.
REQ-023 Any change in KeyLevel (release, or a second key pressed) SHALL return the FSM to IDLE and clear the counter; zero or more than one key held SHALL suppress repeat.
REQ-024 Macro not defined: no repeat counter or FSM is present; exactly one KeyPress pulse per accepted press.

Verification (DEBOUNCE_CNT=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 unless noted)
REQ-025 Hold Left low from edge 0 -> KeyLevel[0]=1 and KeyPress=5'b00001 after edge 5, KeyPress=0 after edge 6.
REQ-026 Pulse Up low for 3 cycles, then high -> KeyLevel and KeyPress stay 0 throughout.
REQ-027 Enter and Right go low on the same edge -> KeyPress=5'b10010 for one cycle, after edge 5.
REQ-028 Hold Down, assert rst for 2 cycles at edge 3, keep Down low -> outputs 0 during reset; KeyPress[3] pulses 5 cycles after rst deasserts.
REQ-029 KEY_REPEAT_EN defined, hold Left for 60 cycles -> KeyPress[0] pulses at edges 5, 25, 33, 41, 49, 57; press Up at edge 30 -> repeats stop; no further pulses on bit 0.
REQ-030 KEY_REPEAT_EN undefined, same Left hold -> exactly one KeyPress[0] pulse, after edge 5.
